me_frame_loader: RTL and testbench

Producer/consumer front end for the motion estimator. It accepts a byte stream containing one 16x16 reference block and one 32x32 search window, and holds them in internal reference and search memories. It serves the estimator's three combinational read ports, AddressR→R and AddressS1/AddressS2→s1/s2, then pulses `start`. It captures motionX/motionY/BestDist on completion and presents them on a valid/ready result port.

---
 rtl/me_frame_loader.sv | 182 ++++++++++++++++++
 tb/tb_me_frame_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_loader.sv
// me_frame_loader
// Front end for the motion estimator. A byte stream carries one 16x16
// reference block (256 bytes) followed by one 32x32 search window
// (1024 bytes), both in raster order. They are stored in internal memories
// that the estimator reads combinationally. Once both are loaded, the block
// pulses start, waits for a rising edge on completed (or a timeout), then
// holds the captured result on a valid/ready port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   byte stream handshake, in_data the byte
//   AddressR -> R       reference memory read port (combinational)
//   AddressS1 -> s1     search memory read port 1 (combinational)
//   AddressS2 -> s2     search memory read port 2 (combinational)
//   start               one-cycle estimator launch pulse
//   completed           estimator done level
//   motionX/motionY/BestDist   estimator result inputs
//   res_valid/res_ready result handshake
//   res_motionX/res_motionY/res_bestdist/res_timeout   captured result
module me_frame_loader #(
   parameter int TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] AddressR,
   input  logic [9:0] AddressS1,
   input  logic [9:0] AddressS2,
   output logic [7:0] R,
   output logic [7:0] s1,
   output logic [7:0] s2,
   output logic       start,
   input  logic       completed,
   input  logic [3:0] motionX,
   input  logic [3:0] motionY,
   input  logic [7:0] BestDist,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_motionX,
   output logic [3:0] res_motionY,
   output logic [7:0] res_bestdist,
   output logic       res_timeout
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_LOAD_R,
      ST_LOAD_S,
      ST_START,
      ST_WAIT,
      ST_RESULT
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  wptr_r_q, wptr_r_d;
   logic [9:0]  wptr_s_q, wptr_s_d;
   logic [15:0] cnt_q, cnt_d;
   logic        completed_prev_q, completed_prev_d;
   logic [3:0]  res_mx_q, res_mx_d;
   logic [3:0]  res_my_q, res_my_d;
   logic [7:0]  res_bd_q, res_bd_d;
   logic        res_to_q, res_to_d;
   logic        we_r, we_s;
   logic        rise;

   // Memories are deliberately not reset; only the write pointers are.
   logic [7:0] r_mem [256];
   logic [7:0] s_mem [1024];

   // Next-state and output decode. Handshake outputs depend on state only.
   always_comb begin
      state_d          = state_q;
      wptr_r_d         = wptr_r_q;
      wptr_s_d         = wptr_s_q;
      cnt_d            = cnt_q;
      completed_prev_d = completed_prev_q;
      res_mx_d         = res_mx_q;
      res_my_d         = res_my_q;
      res_bd_d         = res_bd_q;
      res_to_d         = res_to_q;
      we_r             = 1'b0;
      we_s             = 1'b0;
      in_ready         = 1'b0;
      start            = 1'b0;
      res_valid        = 1'b0;
      rise             = completed && !completed_prev_q;

      case (state_q)
         ST_LOAD_R: begin
            in_ready = 1'b1;
            if (in_valid) begin
               we_r     = 1'b1;
               wptr_r_d = wptr_r_q + 8'd1;
               if (wptr_r_q == 8'hFF) state_d = ST_LOAD_S;
            end
         end
         ST_LOAD_S: begin
            in_ready = 1'b1;
            if (in_valid) begin
               we_s     = 1'b1;
               wptr_s_d = wptr_s_q + 10'd1;
               if (wptr_s_q == 10'h3FF) state_d = ST_START;
            end
         end
         ST_START: begin
            start = 1'b1;
            cnt_d = 16'd0;
            // Sampling completed here keeps a level stuck high across START
            // from looking like a fresh completion in the first WAIT cycle.
            completed_prev_d = completed;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            completed_prev_d = completed;
            cnt_d = cnt_q + 16'd1;
            // A real completion wins over a timeout in the same cycle.
            if (rise) begin
               res_mx_d = motionX;
               res_my_d = motionY;
               res_bd_d = BestDist;
               res_to_d = 1'b0;
               state_d  = ST_RESULT;
            end else if (cnt_q == CNT_LAST) begin
               res_mx_d = 4'd0;
               res_my_d = 4'd0;
               res_bd_d = 8'hFF;
               res_to_d = 1'b1;
               state_d  = ST_RESULT;
            end
         end
         ST_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_d = ST_LOAD_R;
         end
         default: state_d = ST_LOAD_R;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_LOAD_R;
         wptr_r_q         <= 8'd0;
         wptr_s_q         <= 10'd0;
         cnt_q            <= 16'd0;
         completed_prev_q <= 1'b0;
         res_mx_q         <= 4'd0;
         res_my_q         <= 4'd0;
         res_bd_q         <= 8'd0;
         res_to_q         <= 1'b0;
      end else begin
         state_q          <= state_d;
         wptr_r_q         <= wptr_r_d;
         wptr_s_q         <= wptr_s_d;
         cnt_q            <= cnt_d;
         completed_prev_q <= completed_prev_d;
         res_mx_q         <= res_mx_d;
         res_my_q         <= res_my_d;
         res_bd_q         <= res_bd_d;
         res_to_q         <= res_to_d;
      end
   end

   // Write ports; reads below are asynchronous, so a same-cycle read of the
   // address being written still returns the old byte.
   always_ff @(posedge clk) begin
      if (we_r) r_mem[wptr_r_q] <= in_data;
      if (we_s) s_mem[wptr_s_q] <= in_data;
   end

   assign R  = r_mem[AddressR];
   assign s1 = s_mem[AddressS1];
   assign s2 = s_mem[AddressS2];

   assign res_motionX  = res_mx_q;
   assign res_motionY  = res_my_q;
   assign res_bestdist = res_bd_q;
   assign res_timeout  = res_to_q;

endmodule

// File: tb/tb_me_frame_loader.sv
// Testbench for me_frame_loader. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_me_frame_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic [7:0] AddressR = 8'd0;
   logic [9:0] AddressS1 = 10'd0;
   logic [9:0] AddressS2 = 10'd0;
   logic [7:0] R, s1, s2;
   logic       start;
   logic       completed = 1'b0;
   logic [3:0] motionX = 4'd0;
   logic [3:0] motionY = 4'd0;
   logic [7:0] BestDist = 8'd0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_motionX, res_motionY;
   logic [7:0] res_bestdist;
   logic       res_timeout;

   int n_cmp = 0;
   int n_fail = 0;

   me_frame_loader #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
      .R(R), .s1(s1), .s2(s2),
      .start(start), .completed(completed),
      .motionX(motionX), .motionY(motionY), .BestDist(BestDist),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_motionX(res_motionX), .res_motionY(res_motionY),
      .res_bestdist(res_bestdist), .res_timeout(res_timeout)
   );

   always #5 clk = ~clk;

   // Stimulus: stream nbeats bytes from beat 0. R bytes are i^rxor and S
   // bytes are j[7:0]^8'h5A. With stall set, in_valid is high every other
   // cycle. start must stay low for the whole feed.
   task automatic feed(input int nbeats, input bit stall, input logic [7:0] rxor);
      int  beats = 0;
      int  cyc = 0;
      int  j;
      bit  early = 1'b0;
      while (beats < nbeats) begin
         @(negedge clk);
         if (start !== 1'b0) early = 1'b1;
         if (!stall || (cyc % 2 == 0)) begin
            in_valid = 1'b1;
            if (beats < 256) begin
               j = beats;
               in_data = j[7:0] ^ rxor;
            end else begin
               j = beats - 256;
               in_data = j[7:0] ^ 8'h5A;
            end
            beats++;
         end else begin
            in_valid = 1'b0;
         end
         cyc++;
      end
      n_cmp++;
      if (early) begin
         n_fail++;
         $display("[TB] FAIL start_early: got start=1 during load, want 0");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({in_ready, start, res_valid} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got ready/start/valid=%b want 100", {in_ready, start, res_valid});
      end
      n_cmp++;
      if ({res_motionX, res_motionY, res_bestdist, res_timeout} !== 17'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_res: got %h/%h/%h/%b want all 0", res_motionX, res_motionY, res_bestdist, res_timeout);
      end
   endtask

   task automatic test_ramp_load();
      feed(1280, 1'b0, 8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if ({start, in_ready} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL ramp_start: got start/in_ready=%b want 10", {start, in_ready});
      end
      @(negedge clk);
      n_cmp++;
      if ({start, in_ready} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL ramp_start_width: got start/in_ready=%b want 00", {start, in_ready});
      end
      AddressR = 8'd37; AddressS1 = 10'd1000; AddressS2 = 10'd0;
      #1;
      n_cmp++;
      if (R !== 8'd37) begin
         n_fail++;
         $display("[TB] FAIL ramp_R37: got %h want 25", R);
      end
      n_cmp++;
      if (s1 !== 8'hB2) begin
         n_fail++;
         $display("[TB] FAIL ramp_s1_1000: got %h want b2", s1);
      end
      n_cmp++;
      if (s2 !== 8'h5A) begin
         n_fail++;
         $display("[TB] FAIL ramp_s2_0: got %h want 5a", s2);
      end
   endtask

   // Continues from the WAIT state left by test_ramp_load.
   task automatic test_normal_completion();
      bit unstable = 1'b0;
      repeat (9) @(negedge clk);
      completed = 1'b1; motionX = 4'd3; motionY = 4'd12; BestDist = 8'd0;
      @(negedge clk);
      motionX = 4'd7; motionY = 4'd1; BestDist = 8'h44;
      n_cmp++;
      if ({res_valid, res_motionX, res_motionY, res_bestdist, res_timeout} !== {1'b1, 4'd3, 4'd12, 8'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL normal_result: got v=%b %0d/%0d/%h to=%b want v=1 3/12/00 to=0", res_valid, res_motionX, res_motionY, res_bestdist, res_timeout);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if ({res_valid, res_motionX, res_motionY, res_bestdist, res_timeout} !== {1'b1, 4'd3, 4'd12, 8'd0, 1'b0}) unstable = 1'b1;
      end
      n_cmp++;
      if (unstable) begin
         n_fail++;
         $display("[TB] FAIL normal_hold: got result changed under backpressure, want stable 3/12/00");
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; completed = 1'b0;
      n_cmp++;
      if ({in_ready, res_valid} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL normal_handshake: got in_ready/res_valid=%b want 10", {in_ready, res_valid});
      end
   endtask

   // Completed is raised before the load so it is stuck high across START.
   task automatic test_stalled_load_stuck_completed();
      bit early = 1'b0;
      completed = 1'b1;
      feed(1280, 1'b1, 8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if ({start, in_ready} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL stall_start: got start/in_ready=%b want 10", {start, in_ready});
      end
      AddressR = 8'd255; AddressS1 = 10'd1000; AddressS2 = 10'd1023;
      #1;
      n_cmp++;
      if ({R, s1, s2} !== {8'hFF, 8'hB2, 8'hA5}) begin
         n_fail++;
         $display("[TB] FAIL stall_mem: got R/s1/s2=%h/%h/%h want ff/b2/a5", R, s1, s2);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (res_valid !== 1'b0) early = 1'b1;
      end
      n_cmp++;
      if (early) begin
         n_fail++;
         $display("[TB] FAIL stuck_no_capture: got res_valid=1 with completed stuck high, want 0");
      end
      completed = 1'b0;
      @(negedge clk);
      completed = 1'b1; motionX = 4'd5; motionY = 4'd6; BestDist = 8'h33;
      @(negedge clk);
      n_cmp++;
      if ({res_valid, res_motionX, res_motionY, res_bestdist, res_timeout} !== {1'b1, 4'd5, 4'd6, 8'h33, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL stuck_capture: got v=%b %0d/%0d/%h to=%b want v=1 5/6/33 to=0", res_valid, res_motionX, res_motionY, res_bestdist, res_timeout);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_timeout();
      bit early = 1'b0;
      completed = 1'b0; motionX = 4'd9; motionY = 4'd9; BestDist = 8'h11;
      feed(1280, 1'b0, 8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (start !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL timeout_start: got start=%b want 1", start);
      end
      @(negedge clk);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (res_valid !== 1'b0) early = 1'b1;
      end
      n_cmp++;
      if (early) begin
         n_fail++;
         $display("[TB] FAIL timeout_early: got res_valid=1 before 16 WAIT cycles, want 0");
      end
      @(negedge clk);
      n_cmp++;
      if ({res_valid, res_motionX, res_motionY, res_bestdist, res_timeout} !== {1'b1, 4'd0, 4'd0, 8'hFF, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL timeout_result: got v=%b %0d/%0d/%h to=%b want v=1 0/0/ff to=1", res_valid, res_motionX, res_motionY, res_bestdist, res_timeout);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   // R is written with i^C3, then 500 S beats, then reset. The old R bytes
   // must survive reset, and a fresh 1280-beat frame is needed for start.
   task automatic test_reset_mid_load();
      feed(756, 1'b0, 8'hC3);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      AddressR = 8'd37;
      #1;
      n_cmp++;
      if ({res_bestdist, res_timeout, start, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL midreset_values: got bd=%h to=%b start=%b rdy=%b want 00/0/0/1", res_bestdist, res_timeout, start, in_ready);
      end
      n_cmp++;
      if (R !== 8'hE6) begin
         n_fail++;
         $display("[TB] FAIL midreset_R_kept: got %h want e6", R);
      end
      @(negedge clk);
      rst_n = 1'b1;
      feed(1280, 1'b0, 8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (start !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midreset_start: got start=%b want 1", start);
      end
      #1;
      n_cmp++;
      if (R !== 8'd37) begin
         n_fail++;
         $display("[TB] FAIL midreset_R_new: got %h want 25", R);
      end
      @(negedge clk);
      completed = 1'b1; motionX = 4'd2; motionY = 4'd4; BestDist = 8'h08;
      @(negedge clk);
      n_cmp++;
      if ({res_valid, res_motionX, res_motionY, res_bestdist} !== {1'b1, 4'd2, 4'd4, 8'h08}) begin
         n_fail++;
         $display("[TB] FAIL midreset_fast_capture: got v=%b %0d/%0d/%h want v=1 2/4/08", res_valid, res_motionX, res_motionY, res_bestdist);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0; completed = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ramp_load();
      test_normal_completion();
      test_stalled_load_stuck_completed();
      test_timeout();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion within time limit, want summary");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
